ram_b_ctrl: RTL

Access scheduler for the layered B-message RAM (P=64, Q=6, N=1024, layers 1..8) of the SCAN decoder. It accepts whole-vector read and write requests over valid/ready handshakes and expands each into per-beat RAM commands: enables, layer, base address and beat count. It also resolves read-after-write hazards on the same layer and tags returned read beats. It sits between the SCAN scheduler/PE array and the B RAM; the write data path (`b_in`) bypasses this block.

---
 rtl/polar_b_pkg.sv | 28 ++
 rtl/b_burst_seq.sv | 94 +++++++++
 rtl/ram_b_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/polar_b_pkg.sv
// Shared constants and beat-count helpers for the layered B-message RAM (P=64, Q=6, N=1024).
// Layers 1..TOP_LAYER are legal; the topmost layers span several RAM beats.
package polar_b_pkg;

  localparam int LAYER_MIN = 1;
  localparam int TOP_LAYER = 8;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_WAIT,
    SEQ_BURST
  } seq_state_t;

  function automatic int wr_beats(input int layer, input int top = TOP_LAYER);
    return (layer == top) ? 2 : 1;
  endfunction

  function automatic int rd_beats(input int layer, input int top = TOP_LAYER);
    if (layer == top) return 4;
    if (layer == top - 1) return 2;
    return 1;
  endfunction

  function automatic logic layer_legal(input int layer, input int top = TOP_LAYER);
    return (layer >= LAYER_MIN) && (layer <= top);
  endfunction

endpackage

// File: rtl/b_burst_seq.sv
// One request sequencer: accepts a request in IDLE and emits beats 0..beats-1 on consecutive cycles.
// First beat one cycle after the handshake (unless deferred); ready only in IDLE and out of reset.
module b_burst_seq
  import polar_b_pkg::*;
#(
  parameter int AW = 9,
  parameter int LW = 5,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [LW-1:0] req_layer,
  input  logic [AW-1:0] req_addr,
  input  logic [CW-1:0] req_beats,
  input  logic          req_legal,
  input  logic          defer,
  input  logic          hold,
  output logic          en,
  output logic [LW-1:0] layer,
  output logic [AW-1:0] addr,
  output logic [CW-1:0] cnt,
  output logic          last,
  output logic [LW-1:0] cur_layer,
  output logic          active
);

  seq_state_t    state, state_nx;
  logic [CW-1:0] cnt_q, cnt_nx;
  logic [CW-1:0] beats_q, beats_nx;
  logic [LW-1:0] layer_q, layer_nx;
  logic [AW-1:0] addr_q, addr_nx;
  logic          fire;
  logic          last_beat;

  assign req_ready = (state == SEQ_IDLE) && !rst;
  assign fire      = req_valid && req_ready;
  assign last_beat = (cnt_q == beats_q - 1'b1);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt_q;
    beats_nx = beats_q;
    layer_nx = layer_q;
    addr_nx  = addr_q;
    unique case (state)
      SEQ_IDLE: begin
        // Illegal requests are swallowed here: accepted but never leave IDLE.
        if (fire && req_legal) begin
          layer_nx = req_layer;
          addr_nx  = req_addr;
          beats_nx = req_beats;
          cnt_nx   = '0;
          state_nx = defer ? SEQ_WAIT : SEQ_BURST;
        end
      end
      SEQ_WAIT: begin
        if (!hold) state_nx = SEQ_BURST;
      end
      SEQ_BURST: begin
        if (last_beat) state_nx = SEQ_IDLE;
        else cnt_nx = cnt_q + 1'b1;
      end
      default: state_nx = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= SEQ_IDLE;
      cnt_q   <= '0;
      beats_q <= '0;
      layer_q <= '0;
      addr_q  <= '0;
    end else begin
      state   <= state_nx;
      cnt_q   <= cnt_nx;
      beats_q <= beats_nx;
      layer_q <= layer_nx;
      addr_q  <= addr_nx;
    end
  end

  // Reset gates the command combinationally so an aborted burst emits nothing in the reset cycle.
  assign en        = (state == SEQ_BURST) && !rst;
  assign layer     = en ? layer_q : '0;
  assign addr      = en ? addr_q : '0;
  assign cnt       = en ? cnt_q : '0;
  assign last      = en && last_beat;
  assign cur_layer = layer_q;
  assign active    = (state != SEQ_IDLE);

endmodule

// File: rtl/ram_b_ctrl.sv
// B-message RAM access scheduler: expands read/write requests into per-beat RAM commands, read waits on same-layer write.
// Beat 0 one cycle after handshake, read return one cycle after each read beat; each side accepts only when idle.
module ram_b_ctrl
#(
  parameter int AW        = 9,
  parameter int LW        = 5,
  parameter int CW        = 4,
  parameter int TOP_LAYER = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [LW-1:0] wr_layer,
  input  logic [AW-1:0] wr_addr,
  input  logic          rd_valid,
  output logic          rd_ready,
  input  logic [LW-1:0] rd_layer,
  input  logic [AW-1:0] rd_addr,
  output logic          ram_w_en,
  output logic [LW-1:0] ram_layer_w,
  output logic [AW-1:0] ram_w_address,
  output logic [CW-1:0] ram_cnta,
  output logic          ram_r_en,
  output logic [LW-1:0] ram_layer_r,
  output logic [AW-1:0] ram_r_address,
  output logic [CW-1:0] ram_cntb,
  output logic          rdata_valid,
  output logic [CW-1:0] rdata_beat,
  output logic          rdata_last,
  output logic          err_layer,
  output logic          busy
);

  import polar_b_pkg::*;

  logic          wr_legal, rd_legal;
  logic [CW-1:0] wr_n, rd_n;
  logic          wr_fire, rd_fire;
  logic          rd_defer, rd_hold;
  logic [LW-1:0] wr_cur_layer, rd_cur_layer;
  logic          wr_active, rd_active;
  logic          wr_last_unused, rd_last;
  logic          rv_q, rl_q, err_q;
  logic [CW-1:0] rb_q;

  assign wr_legal = layer_legal(int'(wr_layer), TOP_LAYER);
  assign rd_legal = layer_legal(int'(rd_layer), TOP_LAYER);
  assign wr_n     = CW'(wr_beats(int'(wr_layer), TOP_LAYER));
  assign rd_n     = CW'(rd_beats(int'(rd_layer), TOP_LAYER));
  assign wr_fire  = wr_valid && wr_ready;
  assign rd_fire  = rd_valid && rd_ready;

  // Same-layer conflicts go to the write: a read parks in WAIT behind an active or simultaneous write.
  assign rd_defer = (ram_w_en && (wr_cur_layer == rd_layer)) ||
                    (wr_fire && wr_legal && (wr_layer == rd_layer));
  assign rd_hold  = ram_w_en || (wr_fire && wr_legal && (wr_layer == rd_cur_layer));

  b_burst_seq #(.AW(AW), .LW(LW), .CW(CW)) u_wr_seq (
    .clk       (clk),
    .rst       (rst),
    .req_valid (wr_valid),
    .req_ready (wr_ready),
    .req_layer (wr_layer),
    .req_addr  (wr_addr),
    .req_beats (wr_n),
    .req_legal (wr_legal),
    .defer     (1'b0),
    .hold      (1'b0),
    .en        (ram_w_en),
    .layer     (ram_layer_w),
    .addr      (ram_w_address),
    .cnt       (ram_cnta),
    .last      (wr_last_unused),
    .cur_layer (wr_cur_layer),
    .active    (wr_active)
  );

  b_burst_seq #(.AW(AW), .LW(LW), .CW(CW)) u_rd_seq (
    .clk       (clk),
    .rst       (rst),
    .req_valid (rd_valid),
    .req_ready (rd_ready),
    .req_layer (rd_layer),
    .req_addr  (rd_addr),
    .req_beats (rd_n),
    .req_legal (rd_legal),
    .defer     (rd_defer),
    .hold      (rd_hold),
    .en        (ram_r_en),
    .layer     (ram_layer_r),
    .addr      (ram_r_address),
    .cnt       (ram_cntb),
    .last      (rd_last),
    .cur_layer (rd_cur_layer),
    .active    (rd_active)
  );

  // Read return tracks the RAM's internal b_out register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rv_q  <= 1'b0;
      rb_q  <= '0;
      rl_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      rv_q  <= ram_r_en;
      rb_q  <= ram_cntb;
      rl_q  <= rd_last;
      err_q <= (wr_fire && !wr_legal) || (rd_fire && !rd_legal);
    end
  end

  assign rdata_valid = rv_q && !rst;
  assign rdata_beat  = rst ? '0 : rb_q;
  assign rdata_last  = rl_q && !rst;
  assign err_layer   = err_q && !rst;
  assign busy        = (wr_active || rd_active) && !rst;

endmodule
